dac_spi_transmitter: RTL and testbench



---
 rtl/dac_spi_pkg.sv | 20 ++
 rtl/dac_sclk_tick_gen.sv | 37 +++
 rtl/dac_spi_transmitter.sv | 182 ++++++++++++++++++
 tb/tb_dac_spi_transmitter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_pkg.sv
// Shared definitions for the DAC SPI transmitter.
//   DAC_WORD_BITS      - width of one DAC sample (MSB shifted first)
//   DEFAULT_SCLK_DIV   - default qzt_clk cycles per SCLK half-period
//   DEFAULT_GAP_CYCLES - default CS_n-high cycles between frames
//   dac_state_e        - frame FSM encoding (StLdac only reachable with DAC_SPI_LDAC_EN)
package dac_spi_pkg;

    localparam int unsigned DAC_WORD_BITS      = 16;
    localparam int unsigned DEFAULT_SCLK_DIV   = 4;
    localparam int unsigned DEFAULT_GAP_CYCLES = 4;

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StTrail,
        StLdac,
        StGap
    } dac_state_e;

endpackage

// File: rtl/dac_sclk_tick_gen.sv
// Half-period tick generator for the DAC serial clock.
//   qzt_clk - system clock
//   reset   - synchronous, active-high reset
//   clear   - restart the half-period count (frame start)
//   tick    - high in the last qzt_clk cycle of each SCLK_DIV-cycle half-period
module dac_sclk_tick_gen #(
    parameter int unsigned SCLK_DIV = 4
) (
    input  logic qzt_clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = $clog2(SCLK_DIV) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SCLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_spi_transmitter.sv
// Serializes one 16-bit sample into a 3-wire SPI frame for an external serial DAC.
// Optional LDAC strobe phase is built only when the macro DAC_SPI_LDAC_EN is defined.
//   qzt_clk      - system clock (only clock)
//   reset        - synchronous, active-high reset
//   sample_valid - request to send sample_in (level-sensitive)
//   sample_in    - sample to send, MSB first
//   busy         - frame in progress, including trailer, LDAC and gap
//   done         - one-cycle pulse when the gap ends
//   overrun      - one-cycle pulse when a new request arrives while busy
//   dac_cs_n     - chip select, active low
//   dac_sclk     - serial clock, idles low
//   dac_mosi     - serial data, changes only while SCLK is low
//   dac_ldac_n   - DAC load strobe, active low
module dac_spi_transmitter
    import dac_spi_pkg::*;
#(
    parameter int unsigned SCLK_DIV   = DEFAULT_SCLK_DIV,
    parameter int unsigned GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic                     qzt_clk,
    input  logic                     reset,
    input  logic                     sample_valid,
    input  logic [DAC_WORD_BITS-1:0] sample_in,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun,
    output logic                     dac_cs_n,
    output logic                     dac_sclk,
    output logic                     dac_mosi,
    output logic                     dac_ldac_n
);

    localparam int unsigned GapW = $clog2(GAP_CYCLES) + 1;
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
    localparam logic [4:0] LastBit = 5'(DAC_WORD_BITS - 1);

    dac_state_e state_q, state_d;
    logic [4:0] bit_cnt_q, bit_cnt_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    logic [DAC_WORD_BITS-1:0] sreg_q, sreg_d;
    logic sclk_q, sclk_d;
    logic valid_q;
    logic cs_n_q, cs_n_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic overrun_q, overrun_d;
    logic ldac_n_q, ldac_n_d;
    logic accept;
    logic tick;
    logic gap_last;

    dac_sclk_tick_gen #(
        .SCLK_DIV(SCLK_DIV)
    ) u_tick_gen (
        .qzt_clk(qzt_clk),
        .reset  (reset),
        .clear  (accept),
        .tick   (tick)
    );

    assign gap_last = (state_q == StGap) && (gap_cnt_q == GapLast);

    // State register (also holds counters, shifter and registered outputs)
    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            sreg_q    <= '0;
            sclk_q    <= 1'b0;
            valid_q   <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            ldac_n_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sreg_q    <= sreg_d;
            sclk_q    <= sclk_d;
            valid_q   <= sample_valid;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            ldac_n_q  <= ldac_n_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = '0;
        sreg_d    = sreg_q;
        sclk_d    = sclk_q;
        accept    = 1'b0;
        case (state_q)
            StIdle: begin
                accept = sample_valid;
            end
            StShift: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling edge: present the next bit in the same cycle
                        sclk_d = 1'b0;
                        if (bit_cnt_q == LastBit) begin
                            state_d = StTrail;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                            sreg_d    = {sreg_q[DAC_WORD_BITS-2:0], 1'b0};
                        end
                    end
                end
            end
            StTrail: begin
                if (tick) begin
                    sreg_d    = '0;
                    bit_cnt_d = '0;
`ifdef DAC_SPI_LDAC_EN
                    state_d   = StLdac;
`else
                    state_d   = StGap;
`endif
                end
            end
`ifdef DAC_SPI_LDAC_EN
            StLdac: begin
                if (tick) begin
                    state_d = StGap;
                end
            end
`endif
            StGap: begin
                // A request seen as the gap ends starts the next frame at once,
                // so held requests produce exactly GAP_CYCLES of CS_n high.
                if (gap_last) begin
                    state_d = StIdle;
                    accept  = sample_valid;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (accept) begin
            state_d   = StShift;
            sreg_d    = sample_in;
            bit_cnt_d = '0;
            sclk_d    = 1'b0;
        end
    end

    // Output logic (registered, so the DAC pins never see decode glitches)
    always_comb begin
        cs_n_d   = !((state_d == StShift) || (state_d == StTrail));
        busy_d   = (state_d != StIdle);
        done_d   = gap_last;
        ldac_n_d = 1'b1;
`ifdef DAC_SPI_LDAC_EN
        ldac_n_d = (state_d != StLdac);
`endif
        // Only a fresh request counts; a held level is the standing request
        // that restarts framing whenever IDLE is reached.
        overrun_d = busy_q && sample_valid && !valid_q && !accept;
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign overrun    = overrun_q;
    assign dac_cs_n   = cs_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_mosi   = sreg_q[DAC_WORD_BITS-1];
    assign dac_ldac_n = ldac_n_q;

endmodule

// File: tb/tb_dac_spi_transmitter.sv
// Self-checking bench for dac_spi_transmitter: table-driven single frames,
// a scoreboard of expected words checked by an SPI bus monitor, and
// hand-written sequences for reset, back-to-back and fast-divider cases.
module tb_dac_spi_transmitter;
    import dac_spi_pkg::*;

    localparam int Div = 4;
    localparam int Gap = 4;
`ifdef DAC_SPI_LDAC_EN
    localparam int LdacLen  = Div;
    localparam int FastLdac = 1;
`else
    localparam int LdacLen  = 0;
    localparam int FastLdac = 0;
`endif
    localparam int CsLow   = 33 * Div;
    localparam int DoneCyc = CsLow + LdacLen + Gap + 1;

    typedef struct packed {
        logic [15:0] word;
        int          pulse_at;
        int          exp_done;
        int          exp_ovr;
    } vec_t;

    logic        qzt_clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [15:0] sample_in;
    logic        busy, done, overrun, dac_cs_n, dac_sclk, dac_mosi, dac_ldac_n;

    logic        f_valid;
    logic [15:0] f_in;
    logic        f_busy, f_done, f_overrun, f_cs_n, f_sclk, f_mosi, f_ldac_n;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];

    always #5 qzt_clk = ~qzt_clk;

    dac_spi_transmitter #(
        .SCLK_DIV  (Div),
        .GAP_CYCLES(Gap)
    ) u_dut (
        .qzt_clk     (qzt_clk),
        .reset       (reset),
        .sample_valid(sample_valid),
        .sample_in   (sample_in),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun),
        .dac_cs_n    (dac_cs_n),
        .dac_sclk    (dac_sclk),
        .dac_mosi    (dac_mosi),
        .dac_ldac_n  (dac_ldac_n)
    );

    dac_spi_transmitter #(
        .SCLK_DIV  (1),
        .GAP_CYCLES(1)
    ) u_fast (
        .qzt_clk     (qzt_clk),
        .reset       (reset),
        .sample_valid(f_valid),
        .sample_in   (f_in),
        .busy        (f_busy),
        .done        (f_done),
        .overrun     (f_overrun),
        .dac_cs_n    (f_cs_n),
        .dac_sclk    (f_sclk),
        .dac_mosi    (f_mosi),
        .dac_ldac_n  (f_ldac_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SPI bus monitor: captures bits on SCLK rising edges, pops the scoreboard
    // when CS_n rises. Frames cut short by reset are discarded.
    logic        prev_sclk = 1'b0;
    logic        prev_cs_n = 1'b1;
    logic        prev_mosi = 1'b0;
    logic        stable_bad = 1'b0;
    int          nbits = 0;
    int          low_len = 0;
    logic [15:0] got_w = '0;
    logic [15:0] exp_w;

    always @(negedge qzt_clk) begin
        if (reset) begin
            nbits      = 0;
            low_len    = 0;
            stable_bad = 1'b0;
        end else begin
            if (!dac_cs_n) low_len++;
            if (dac_sclk && (dac_mosi !== prev_mosi)) stable_bad = 1'b1;
            if (dac_sclk && !prev_sclk) begin
                got_w = {got_w[14:0], dac_mosi};
                nbits++;
            end
            if (dac_cs_n && !prev_cs_n) begin
                if (exp_q.size() == 0) begin
                    check("frame_unexpected", 32'(nbits), 32'd0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("frame_bits", 32'(got_w), 32'(exp_w));
                    check("sclk_rises", 32'(nbits), 32'd16);
                    check("cs_low_len", 32'(low_len), 32'(CsLow));
                    check("mosi_stable", 32'(stable_bad), 32'd0);
                end
                nbits      = 0;
                low_len    = 0;
                stable_bad = 1'b0;
            end
        end
        prev_sclk = dac_sclk;
        prev_cs_n = dac_cs_n;
        prev_mosi = dac_mosi;
    end

    // Per-frame statistics, cycle numbers relative to acceptance (cycle 0)
    int cyc, n_cs_low, n_done, first_done, n_ovr, first_ovr, busy_at_done;

    task automatic step();
        @(negedge qzt_clk);
        cyc++;
        if (!dac_cs_n) n_cs_low++;
        if (done) begin
            n_done++;
            if (first_done < 0) begin
                first_done   = cyc;
                busy_at_done = int'(busy);
            end
        end
        if (overrun) begin
            n_ovr++;
            if (first_ovr < 0) first_ovr = cyc;
        end
    endtask

    task automatic start(input logic [15:0] w);
        sample_valid = 1'b1;
        sample_in    = w;
        exp_q.push_back(w);
        cyc          = 0;
        n_cs_low     = 0;
        n_done       = 0;
        first_done   = -1;
        n_ovr        = 0;
        first_ovr    = -1;
        busy_at_done = -1;
    endtask

    task automatic run_single(input vec_t v);
        start(v.word);
        while (first_done < 0 && cyc < 400) begin
            step();
            if (cyc == 1) begin
                check("start_cs_n", 32'(dac_cs_n), 32'd0);
                sample_valid = 1'b0;
                sample_in    = v.word ^ 16'h0F0F;
            end
            if (cyc == v.pulse_at) begin
                sample_valid = 1'b1;
                sample_in    = ~v.word;
            end
            if (cyc == v.pulse_at + 1) sample_valid = 1'b0;
        end
        check("done_cycle", 32'(first_done), 32'(v.exp_done));
        check("cs_low_cycles", 32'(n_cs_low), 32'(CsLow));
        check("first_overrun", 32'(first_ovr), 32'(v.exp_ovr));
        check("busy_at_done", 32'(busy_at_done), 32'd0);
        step();
    endtask

    vec_t vecs[4];
    int   gap_meas, hi_run;
    int   f_low, f_ldac, f_ldac_cs, f_nb, f_done_cyc, f_busy_done, f_ovr;
    logic [15:0] f_bits;

    initial begin
        vecs[0] = '{16'hA5C3, -1, DoneCyc, -1};
        vecs[1] = '{16'h0001, -1, DoneCyc, -1};
        vecs[2] = '{16'hFFFF, -1, DoneCyc, -1};
        vecs[3] = '{16'h5A3C, 40, DoneCyc, 41};

        // Reset held 3 cycles with a pending request
        reset        = 1'b1;
        sample_valid = 1'b1;
        sample_in    = 16'h1234;
        f_valid      = 1'b0;
        f_in         = '0;
        repeat (3) @(negedge qzt_clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_cs_n", 32'(dac_cs_n), 32'd1);
        check("rst_sclk", 32'(dac_sclk), 32'd0);
        check("rst_mosi", 32'(dac_mosi), 32'd0);
        check("rst_ldac_n", 32'(dac_ldac_n), 32'd1);
        reset = 1'b0;
        run_single('{16'h1234, -1, DoneCyc, -1});

        // Table-driven single frames, including a mid-frame overrun pulse
        for (int i = 0; i < 4; i++) begin
            run_single(vecs[i]);
        end

        // Held request: two back-to-back frames
        start(16'h0001);
        gap_meas = -1;
        hi_run   = 0;
        while (n_done < 2 && cyc < 600) begin
            step();
            if (cyc == 1) begin
                sample_in = 16'hFFFE;
                exp_q.push_back(16'hFFFE);
            end
            if (first_done > 0) sample_valid = 1'b0;
            if (dac_cs_n) hi_run++;
            else if (hi_run > 0 && gap_meas < 0) gap_meas = hi_run;
        end
        check("b2b_gap", 32'(gap_meas), 32'(Gap + LdacLen));
        check("b2b_overrun", 32'(n_ovr), 32'd0);
        check("b2b_done_count", 32'(n_done), 32'd2);
        check("b2b_first_done", 32'(first_done), 32'(DoneCyc));
        check("b2b_cs_low", 32'(n_cs_low), 32'(2 * CsLow));
        step();

        // Reset mid-frame aborts without done
        start(16'hFFFF);
        while (cyc < 50) begin
            step();
            if (cyc == 1) sample_valid = 1'b0;
        end
        reset = 1'b1;
        step();
        check("abort_cs_n", 32'(dac_cs_n), 32'd1);
        check("abort_sclk", 32'(dac_sclk), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        step();
        reset = 1'b0;
        exp_q.delete();
        repeat (150) step();
        check("abort_no_done", 32'(n_done), 32'd0);
        run_single('{16'h0000, -1, DoneCyc, -1});
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // Fastest divider on the second instance
        f_low       = 0;
        f_ldac      = 0;
        f_ldac_cs   = 0;
        f_nb        = 0;
        f_done_cyc  = -1;
        f_busy_done = -1;
        f_ovr       = 0;
        f_bits      = '0;
        f_valid     = 1'b1;
        f_in        = 16'h8001;
        for (int c = 1; c <= 60; c++) begin
            @(negedge qzt_clk);
            if (c == 1) f_valid = 1'b0;
            if (!f_cs_n) f_low++;
            if (!f_ldac_n) begin
                f_ldac++;
                if (!f_cs_n) f_ldac_cs++;
            end
            if (f_sclk) begin
                f_bits = {f_bits[14:0], f_mosi};
                f_nb++;
            end
            if (f_overrun) f_ovr++;
            if (f_done && f_done_cyc < 0) begin
                f_done_cyc  = c;
                f_busy_done = int'(f_busy);
            end
        end
        check("fast_cs_low", 32'(f_low), 32'd33);
        check("fast_ldac_low", 32'(f_ldac), 32'(FastLdac));
        check("fast_ldac_cs_overlap", 32'(f_ldac_cs), 32'd0);
        check("fast_bits", 32'(f_bits), 32'h8001);
        check("fast_bit_count", 32'(f_nb), 32'd16);
        check("fast_done_cycle", 32'(f_done_cyc), 32'(33 + FastLdac + 1 + 1));
        check("fast_busy_at_done", 32'(f_busy_done), 32'd0);
        check("fast_overrun", 32'(f_ovr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
